prefix_adder_arbiter: RTL and testbench
=======================================

PREFIX_ADDER_ARBITER -- requirements
Module: prefix_adder_arbiter

Interface
REQ-001 Parameter LAT, default 5: fixed pipeline latency of the shared prefixadder instance, in clock edges from operand capture to sum/cout valid.
REQ-002 Parameter W, default 32: operand/sum width.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0_valid, req1_valid  input  1 each  requester n presents an operation.
REQ-006 req0_ready, req1_ready  output  1 each  operation accepted at this edge if valid also high.
REQ-007 req0_a, req0_b, req1_a, req1_b  input  W each  operands.
REQ-008 req0_c, req1_c  input  1 each  carry-in.
REQ-009 resp0_valid, resp1_valid  output  1 each  one-cycle result strobe to requester n; no backpressure.
REQ-010 resp_sum  output  W  shared result bus, meaningful only while a resp_valid is high.
REQ-011 resp_cout  output  1  shared carry-out, same qualification.
REQ-012 busy  output  1  high while any accepted operation has not yet produced its response.

Function
REQ-013 At most one operation SHALL be accepted per cycle; reqN_ready is high only for the granted requester, low for the other.
REQ-014 Grant: if only one reqN_valid is high, that requester is granted; if both are high, round-robin: grant goes to the requester not granted at the most recent accept.
REQ-015 reqN_ready SHALL be a combinational function of both valids and the round-robin pointer; no ready without valid.
REQ-016 On accept, a, b, c of the winner are registered into the operand stage feeding the adder, with a tag (requester id) and a valid bit.
REQ-017 In cycles with no accept, the operand stage SHALL load a=0, b=0, c=0, valid=0.
REQ-018 The tag/valid pair SHALL travel through an LAT-deep shift register aligned to the adder pipeline.
REQ-019 Latency: an operation accepted at edge k produces respN_valid=1 for exactly the cycle after edge k+1+LAT, with resp_sum = (a+b+c) mod 2^W and resp_cout = carry out of bit W-1.
REQ-020 respN_valid SHALL assert only for the tag's requester; never both in the same cycle.
REQ-021 Back-to-back accepts SHALL yield back-to-back responses in acceptance order; throughput one op per cycle.
REQ-022 Carry-in SHALL propagate fully: 0xFFFFFFFF+0, c=1 gives sum 0, cout 1.
REQ-023 busy = OR of the operand-stage valid bit and all shift-register valid bits.
REQ-024 Inputs changing while reqN_ready is low SHALL have no effect.

Reset
REQ-025 While reset is high at an edge: all valid bits cleared, round-robin pointer set so requester 0 wins the next tie, operand stage zeroed.
REQ-026 During and after reset: req0_ready=req1_ready=0 while reset is high; resp0_valid=resp1_valid=0, resp_sum=0, resp_cout=0, busy=0 from the first edge with reset high.
REQ-027 Reset mid-operation: every in-flight operation is discarded; no respN_valid for it after reset, even though the unreset adder datapath still carries stale data.

Structure
REQ-028 Shared package holds W default, LAT default, and the tag encoding constants (REQ_ID0=0, REQ_ID1=1).
REQ-029 One sub-module: the existing prefixadder (ports a, b, c, sum, cout, clock), instantiated once; arbitration, operand stage and tag pipeline live in prefix_adder_arbiter.
REQ-030 The adder has no reset; all qualification comes from the tag pipeline.

Verification
REQ-031 Single op: req0 a=10 b=20 c=0 accepted at edge k -> resp0_valid only after edge k+1+LAT, sum=30 cout=0; resp1_valid stays 0.
REQ-032 Tie: both valid continuously, req0 (56+68, c=1), req1 (156+750, c=1) -> grants alternate 0,1,0,1; responses 125 to req0 and 907 to req1, alternating on consecutive cycles.
REQ-033 Back-to-back req1: 5+7, 123+787, 15+72 on three consecutive cycles -> resp1_valid three consecutive cycles, sums 12, 910, 87 in order.
REQ-034 Overflow: req0 a=0xFFFFFFFF b=1 c=0 -> sum 0 cout 1; a=0xFFFFFFFF b=0 c=1 -> sum 0 cout 1.
REQ-035 Reset mid-flight: accept 3 ops, assert reset for 1 cycle at edge k+2 -> no respN_valid for 2*LAT cycles after; busy=0; next tie goes to req0.
REQ-036 Idle/hold: req1_valid high with ready low for 1 cycle (req0 granted) and operands changed -> req1 result reflects operands present at its accept edge (55+71=126).

Source files
------------

// File: rtl/prefix_adder_arbiter_pkg.sv
// Shared definitions for the two-requester arbiter wrapped around the pipelined prefix adder.
// Holds the default sizes and the tag encoding carried beside each operation.
package prefix_adder_arbiter_pkg;

    localparam int W_DEFAULT   = 32;
    localparam int LAT_DEFAULT = 5;

    typedef logic req_id_t;

    localparam req_id_t REQ_ID0 = 1'b0;
    localparam req_id_t REQ_ID1 = 1'b1;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

endpackage

// File: rtl/prefix_adder_arbiter_if.sv
// Request/response bundle between two requesters and the shared adder arbiter.
// The master side presents operations; the slave side grants them and returns results.
interface prefix_adder_arbiter_if
    import prefix_adder_arbiter_pkg::*;
#(
    parameter int W = W_DEFAULT
);
    logic         req0_valid;
    logic         req1_valid;
    logic         req0_ready;
    logic         req1_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req0_c;
    logic         req1_c;
    logic         resp0_valid;
    logic         resp1_valid;
    logic [W-1:0] resp_sum;
    logic         resp_cout;
    logic         busy;

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_c, req1_c,
        input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp_sum, resp_cout, busy
    );

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_c, req1_c,
        output req0_ready, req1_ready, resp0_valid, resp1_valid, resp_sum, resp_cout, busy
    );

endinterface

// File: rtl/prefix_adder_arbiter_prefixadder.sv
// Kogge-Stone prefix adder followed by a LAT-deep register line; no reset, the
// surrounding logic qualifies every result with its own valid pipeline.
module prefixadder
    import prefix_adder_arbiter_pkg::*;
#(
    parameter int W   = W_DEFAULT,
    parameter int LAT = LAT_DEFAULT
) (
    input  logic         clock,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c,
    output logic [W-1:0] sum,
    output logic         cout
);
    // Carry-in rides as bit 0 of an extended (W+1)-bit generate/propagate vector.
    localparam int N      = W + 1;
    localparam int LEVELS = $clog2(N);
    localparam int IW     = $clog2(N);
    localparam int LINE_W = LAT * (W + 1);

    logic [W-1:0]            sum_c;
    logic                    cout_c;
    logic [LAT-1:0][W:0]     stage;

    // NOTE: every variable written here gets a value before any branch or loop,
    // so no path leaves it holding its old value and no latch is inferred.
    always_comb begin : prefix_tree
        logic [N-1:0] g;
        logic [N-1:0] p;
        logic [N-1:0] g_nxt;
        logic [N-1:0] p_nxt;
        g      = {a & b, c};
        p      = {a ^ b, 1'b0};
        g_nxt  = g;
        p_nxt  = p;
        for (int l = 0; l < LEVELS; l++) begin
            g_nxt = g;
            p_nxt = p;
            for (int i = (1 << l); i < N; i++) begin
                g_nxt[IW'(i)] = g[IW'(i)] | (p[IW'(i)] & g[IW'(i - (1 << l))]);
                p_nxt[IW'(i)] = p[IW'(i)] & p[IW'(i - (1 << l))];
            end
            g = g_nxt;
            p = p_nxt;
        end
        sum_c  = (a ^ b) ^ g[W-1:0];
        cout_c = g[W];
    end

    // NOTE: the result line is pure datapath and is deliberately left without
    // reset; stale contents are harmless because nothing downstream trusts them
    // without a matching valid bit.
    always_ff @(posedge clock) begin
        stage <= LINE_W'({stage, cout_c, sum_c});
    end

    assign {cout, sum} = stage[LAT-1];

endmodule

// File: rtl/prefix_adder_arbiter.sv
// Round-robin arbiter sharing one pipelined prefix adder between two requesters;
// a tag pipeline alongside the adder steers each result back to its owner.
module prefix_adder_arbiter
    import prefix_adder_arbiter_pkg::*;
#(
    parameter int W   = W_DEFAULT,
    parameter int LAT = LAT_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    prefix_adder_arbiter_if.slave  bus
);
    localparam int TAG_LINE_W = LAT * $bits(tag_t);

    req_id_t             last_grant;
    logic                grant0;
    logic                grant1;
    logic                accept;
    req_id_t             win_id;

    logic [W-1:0]        op_a;
    logic [W-1:0]        op_b;
    logic                op_c;
    tag_t                op_tag;

    tag_t [LAT-1:0]      tag_pipe;
    tag_t                out_tag;
    logic [LAT-1:0]      pipe_valid;

    logic [W-1:0]        add_sum;
    logic                add_cout;

    logic                resp0_q;
    logic                resp1_q;
    logic [W-1:0]        resp_sum_q;
    logic                resp_cout_q;

    // A tie goes to whichever requester lost the most recent accept.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = (last_grant == REQ_ID1);
                grant1 = (last_grant == REQ_ID0);
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    assign accept         = grant0 | grant1;
    assign win_id         = grant1 ? REQ_ID1 : REQ_ID0;
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= REQ_ID1;
            op_a       <= '0;
            op_b       <= '0;
            op_c       <= 1'b0;
            op_tag     <= '{valid: 1'b0, id: REQ_ID0};
        end else if (accept) begin
            last_grant <= win_id;
            op_a       <= grant1 ? bus.req1_a : bus.req0_a;
            op_b       <= grant1 ? bus.req1_b : bus.req0_b;
            op_c       <= grant1 ? bus.req1_c : bus.req0_c;
            op_tag     <= '{valid: 1'b1, id: win_id};
        end else begin
            op_a       <= '0;
            op_b       <= '0;
            op_c       <= 1'b0;
            op_tag     <= '{valid: 1'b0, id: REQ_ID0};
        end
    end

    prefixadder #(
        .W   (W),
        .LAT (LAT)
    ) u_adder (
        .clock (clock),
        .a     (op_a),
        .b     (op_b),
        .c     (op_c),
        .sum   (add_sum),
        .cout  (add_cout)
    );

    // Tag line shifts in lockstep with the adder's result line.
    always_ff @(posedge clock) begin
        if (reset) begin
            tag_pipe <= '0;
        end else begin
            tag_pipe <= TAG_LINE_W'({tag_pipe, op_tag});
        end
    end

    assign out_tag = tag_pipe[LAT-1];

    for (genvar i = 0; i < LAT; i++) begin : g_valid
        assign pipe_valid[i] = tag_pipe[i].valid;
    end

    // Result bus is forced to zero outside a strobe so stale adder data never leaks.
    always_ff @(posedge clock) begin
        if (reset) begin
            resp0_q     <= 1'b0;
            resp1_q     <= 1'b0;
            resp_sum_q  <= '0;
            resp_cout_q <= 1'b0;
        end else begin
            resp0_q     <= out_tag.valid && (out_tag.id == REQ_ID0);
            resp1_q     <= out_tag.valid && (out_tag.id == REQ_ID1);
            resp_sum_q  <= out_tag.valid ? add_sum : '0;
            resp_cout_q <= out_tag.valid & add_cout;
        end
    end

    assign bus.resp0_valid = resp0_q;
    assign bus.resp1_valid = resp1_q;
    assign bus.resp_sum    = resp_sum_q;
    assign bus.resp_cout   = resp_cout_q;
    assign bus.busy        = op_tag.valid | (|pipe_valid);

endmodule

// File: tb/tb_prefix_adder_arbiter.sv
// Directed bench for prefix_adder_arbiter: arbitration, latency, carries,
// operand hold while not ready, and reset in the middle of traffic.
module tb_prefix_adder_arbiter;
    localparam int W   = 32;
    localparam int LAT = 5;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    prefix_adder_arbiter_if #(.W(W)) bus ();

    prefix_adder_arbiter #(
        .W   (W),
        .LAT (LAT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic drive0(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        bus.req0_valid = 1'b1;
        bus.req0_a     = a;
        bus.req0_b     = b;
        bus.req0_c     = c;
    endtask

    task automatic drive1(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        bus.req1_valid = 1'b1;
        bus.req1_a     = a;
        bus.req1_b     = b;
        bus.req1_c     = c;
    endtask

    task automatic check_ready(input string tag, input logic r0, input logic r1);
        #1;
        check({tag, " ready0"}, bus.req0_ready, r0);
        check({tag, " ready1"}, bus.req1_ready, r1);
    endtask

    task automatic quiet(input int n, input string tag);
        repeat (n) begin
            tick();
            check({tag, " quiet resp0"}, bus.resp0_valid, 1'b0);
            check({tag, " quiet resp1"}, bus.resp1_valid, 1'b0);
        end
    endtask

    task automatic expect_resp(input string tag, input int id, input logic [W-1:0] s, input logic co);
        tick();
        check({tag, " resp0_valid"}, bus.resp0_valid, id == 0);
        check({tag, " resp1_valid"}, bus.resp1_valid, id == 1);
        check({tag, " sum"}, bus.resp_sum, s);
        check({tag, " cout"}, bus.resp_cout, co);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.req0_a = '0; bus.req0_b = '0; bus.req0_c = 1'b0;
        bus.req1_a = '0; bus.req1_b = '0; bus.req1_c = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;

        // Reset: no ready while reset is high, outputs clear after first edge
        check_ready("in_reset", 1'b0, 1'b0);
        tick();
        check("rst resp0_valid", bus.resp0_valid, 1'b0);
        check("rst resp1_valid", bus.resp1_valid, 1'b0);
        check("rst resp_sum", bus.resp_sum, '0);
        check("rst resp_cout", bus.resp_cout, 1'b0);
        check("rst busy", bus.busy, 1'b0);
        reset = 1'b0;

        // Tie: grants alternate 0,1,0,1 starting with req0
        drive0(32'd56, 32'd68, 1'b1);
        drive1(32'd156, 32'd750, 1'b1);
        check_ready("tie g0", 1'b1, 1'b0);
        tick();
        check_ready("tie g1", 1'b0, 1'b1);
        tick();
        check_ready("tie g2", 1'b1, 1'b0);
        tick();
        check_ready("tie g3", 1'b0, 1'b1);
        tick();
        idle();
        check("tie busy", bus.busy, 1'b1);
        quiet(LAT - 3, "tie");
        expect_resp("tie r0a", 0, 32'd125, 1'b0);
        expect_resp("tie r1a", 1, 32'd907, 1'b0);
        expect_resp("tie r0b", 0, 32'd125, 1'b0);
        expect_resp("tie r1b", 1, 32'd907, 1'b0);
        check("tie busy done", bus.busy, 1'b0);

        // Single op latency
        drive0(32'd10, 32'd20, 1'b0);
        check_ready("single", 1'b1, 1'b0);
        tick();
        idle();
        check("single busy", bus.busy, 1'b1);
        quiet(LAT, "single");
        expect_resp("single", 0, 32'd30, 1'b0);
        check("single busy after", bus.busy, 1'b0);
        quiet(1, "single strobe");

        // Back-to-back req1
        drive1(32'd5, 32'd7, 1'b0);
        tick();
        drive1(32'd123, 32'd787, 1'b0);
        check_ready("b2b", 1'b0, 1'b1);
        tick();
        drive1(32'd15, 32'd72, 1'b0);
        tick();
        idle();
        quiet(LAT - 2, "b2b");
        expect_resp("b2b 1", 1, 32'd12, 1'b0);
        expect_resp("b2b 2", 1, 32'd910, 1'b0);
        expect_resp("b2b 3", 1, 32'd87, 1'b0);
        quiet(1, "b2b end");

        // Hold: req1 waits one cycle while its operands change
        drive0(32'd1, 32'd2, 1'b0);
        drive1(32'd99, 32'd99, 1'b0);
        check_ready("hold wait", 1'b1, 1'b0);
        tick();
        bus.req0_valid = 1'b0;
        drive1(32'd55, 32'd71, 1'b0);
        check_ready("hold grant", 1'b0, 1'b1);
        tick();
        idle();
        quiet(LAT - 1, "hold");
        expect_resp("hold r0", 0, 32'd3, 1'b0);
        expect_resp("hold r1", 1, 32'd126, 1'b0);
        quiet(1, "hold end");

        // Carry propagation and overflow
        drive0(32'hFFFF_FFFF, 32'd1, 1'b0);
        tick();
        drive0(32'hFFFF_FFFF, 32'd0, 1'b1);
        tick();
        drive0(32'h7FFF_FFFF, 32'd1, 1'b0);
        tick();
        drive0(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        tick();
        idle();
        quiet(LAT - 3, "ovf");
        expect_resp("ovf b=1", 0, 32'h0000_0000, 1'b1);
        expect_resp("ovf cin", 0, 32'h0000_0000, 1'b1);
        expect_resp("ovf msb", 0, 32'h8000_0000, 1'b0);
        expect_resp("ovf mix", 0, 32'hACF1_3569, 1'b0);
        quiet(1, "ovf end");

        // Reset with three operations in flight
        drive0(32'd1, 32'd1, 1'b0);
        tick();
        bus.req0_valid = 1'b0;
        drive1(32'd2, 32'd2, 1'b0);
        tick();
        bus.req1_valid = 1'b0;
        drive0(32'd3, 32'd3, 1'b0);
        tick();
        reset = 1'b1;
        drive1(32'd4, 32'd4, 1'b0);
        check_ready("midrst", 1'b0, 1'b0);
        tick();
        check("midrst busy", bus.busy, 1'b0);
        check("midrst sum", bus.resp_sum, '0);
        reset = 1'b0;
        idle();
        quiet(2 * LAT, "midrst");
        check("midrst busy after", bus.busy, 1'b0);
        drive0(32'd40, 32'd2, 1'b0);
        drive1(32'd7, 32'd7, 1'b0);
        check_ready("post rst tie", 1'b1, 1'b0);
        tick();
        idle();
        quiet(LAT, "post rst");
        expect_resp("post rst", 0, 32'd42, 1'b0);
        quiet(1, "post rst end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
